// File: rtl/mem_arbiter_pkg.sv
// Shared bus encodings, tag width and tag-table entry types for the memory arbiter.
package sys_defs;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  localparam int TAG_W = 4;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic       valid;
    arb_owner_e owner;
    logic       drop;
  } tag_ent_t;

endpackage

// File: rtl/mem_arbiter_tag_tbl.sv
// Tag table: records owner of each in-flight load, marks fetches dropped on flush,
// looks up completions and keeps the outstanding-load count.
module mem_arb_tag_tbl
  import sys_defs::*;
#(
  parameter int TAG_W      = sys_defs::TAG_W,
  parameter int MAX_OUTSTD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  arb_owner_e       alloc_owner,
  input  logic             flush,
  input  logic [TAG_W-1:0] cmpl_tag,
  output logic             cmpl_deliver,
  output arb_owner_e       cmpl_owner,
  output logic             full,
  output logic [TAG_W-1:0] outstd_cnt
);

  localparam int DEPTH = 2 ** TAG_W;

  tag_ent_t         tbl [DEPTH];
  tag_ent_t         cmpl_ent;
  logic             cmpl_hit;
  logic [TAG_W-1:0] cnt;

  assign cmpl_ent   = tbl[cmpl_tag];
  assign cmpl_hit   = (cmpl_tag != '0) && cmpl_ent.valid;
  assign cmpl_owner = cmpl_ent.owner;
  // A fetch return landing on the flush edge already belongs to the dead path.
  assign cmpl_deliver = cmpl_hit && !cmpl_ent.drop &&
                        !(flush && (cmpl_ent.owner == OWN_IC));
  assign full       = (cnt == TAG_W'(MAX_OUTSTD));
  assign outstd_cnt = cnt;

  // Allocation wins over completion and flush so a re-used tag keeps its new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en && (alloc_tag == TAG_W'(i)))
          tbl[i] <= '{valid: 1'b1, owner: alloc_owner, drop: 1'b0};
        else if (cmpl_hit && (cmpl_tag == TAG_W'(i)))
          tbl[i].valid <= 1'b0;
        else if (flush && tbl[i].valid && (tbl[i].owner == OWN_IC))
          tbl[i].drop <= 1'b1;
      end
      if (alloc_en && !cmpl_hit)
        cnt <= cnt + TAG_W'(1);
      else if (!alloc_en && cmpl_hit)
        cnt <= cnt - TAG_W'(1);
    end
  end

  busy_tag_alloc: assert property (@(posedge clk) disable iff (rst)
    (alloc_en && !(cmpl_hit && (cmpl_tag == alloc_tag))) |-> !tbl[alloc_tag].valid);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto the proc2mem bus and routes tagged returns.
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed dcache priority.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int TAG_W      = sys_defs::TAG_W,
  parameter int MAX_OUTSTD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_req_vld_i,
  input  logic [63:0]      ic_req_addr_i,
  output logic             ic_req_ack_o,
  output logic [TAG_W-1:0] ic_req_tag_o,
  input  logic             ic_flush_i,
  input  logic             dc_req_vld_i,
  input  logic [1:0]       dc_req_cmd_i,
  input  logic [63:0]      dc_req_addr_i,
  input  logic [63:0]      dc_req_data_i,
  output logic             dc_req_ack_o,
  output logic [TAG_W-1:0] dc_req_tag_o,
  output logic             ic_rsp_vld_o,
  output logic [TAG_W-1:0] ic_rsp_tag_o,
  output logic [63:0]      ic_rsp_data_o,
  output logic             dc_rsp_vld_o,
  output logic [TAG_W-1:0] dc_rsp_tag_o,
  output logic [63:0]      dc_rsp_data_o,
  output logic [1:0]       proc2mem_command_o,
  output logic [63:0]      proc2mem_addr_o,
  output logic [63:0]      proc2mem_data_o,
  input  logic [TAG_W-1:0] mem2proc_response_i,
  input  logic [63:0]      mem2proc_data_i,
  input  logic [TAG_W-1:0] mem2proc_tag_i,
  output logic [TAG_W-1:0] arb_outstd_cnt_o
);

  // Handshake: a client holds valid and its payload until it sees ack; ack is
  // combinational, set only for the cycle the winner's command is accepted by memory.
  logic       full, cmpl_deliver;
  arb_owner_e cmpl_owner, alloc_owner;
  logic       dc_is_load, dc_elig, ic_elig;
  logic       grant_dc, grant_ic, resp_ok, ic_ack, dc_ack, alloc_en;

  assign dc_is_load = (dc_req_cmd_i == BUS_LOAD);
  assign dc_elig    = !rst && dc_req_vld_i && !(dc_is_load && full);
  assign ic_elig    = !rst && ic_req_vld_i && !full;

`ifdef MEM_ARB_RR_EN
  arb_owner_e prio;

  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (prio == OWN_DC) begin
      grant_dc = dc_elig;
      grant_ic = ic_elig && !dc_elig;
    end else begin
      grant_ic = ic_elig;
      grant_dc = dc_elig && !ic_elig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prio <= OWN_DC;
    else if (ic_ack) prio <= OWN_DC;
    else if (dc_ack) prio <= OWN_IC;
  end
`else
  assign grant_dc = dc_elig;
  assign grant_ic = ic_elig && !dc_req_vld_i;
`endif

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    if (grant_dc) begin
      proc2mem_command_o = dc_req_cmd_i;
      proc2mem_addr_o    = dc_req_addr_i;
      proc2mem_data_o    = dc_req_data_i;
    end else if (grant_ic) begin
      proc2mem_command_o = BUS_LOAD;
      proc2mem_addr_o    = ic_req_addr_i;
    end
  end

  assign resp_ok      = (mem2proc_response_i != '0);
  assign ic_ack       = grant_ic && resp_ok;
  assign dc_ack       = grant_dc && resp_ok;
  assign ic_req_ack_o = ic_ack;
  assign dc_req_ack_o = dc_ack;
  assign ic_req_tag_o = mem2proc_response_i;
  assign dc_req_tag_o = mem2proc_response_i;

  // Stores complete on ack and never occupy a table entry.
  assign alloc_en    = ic_ack || (dc_ack && dc_is_load);
  assign alloc_owner = ic_ack ? OWN_IC : OWN_DC;

  mem_arb_tag_tbl #(
    .TAG_W     (TAG_W),
    .MAX_OUTSTD(MAX_OUTSTD)
  ) u_tag_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response_i),
    .alloc_owner (alloc_owner),
    .flush       (ic_flush_i),
    .cmpl_tag    (mem2proc_tag_i),
    .cmpl_deliver(cmpl_deliver),
    .cmpl_owner  (cmpl_owner),
    .full        (full),
    .outstd_cnt  (arb_outstd_cnt_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_rsp_vld_o  <= 1'b0;
      ic_rsp_tag_o  <= '0;
      ic_rsp_data_o <= '0;
      dc_rsp_vld_o  <= 1'b0;
      dc_rsp_tag_o  <= '0;
      dc_rsp_data_o <= '0;
    end else begin
      ic_rsp_vld_o <= cmpl_deliver && (cmpl_owner == OWN_IC);
      dc_rsp_vld_o <= cmpl_deliver && (cmpl_owner == OWN_DC);
      if (cmpl_deliver && (cmpl_owner == OWN_IC)) begin
        ic_rsp_tag_o  <= mem2proc_tag_i;
        ic_rsp_data_o <= mem2proc_data_i;
      end
      if (cmpl_deliver && (cmpl_owner == OWN_DC)) begin
        dc_rsp_tag_o  <= mem2proc_tag_i;
        dc_rsp_data_o <= mem2proc_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one default instance plus a MAX_OUTSTD=2 instance
// sharing the same stimulus for the saturation steps.
module tb_mem_arbiter;
  import sys_defs::*;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_vld, ic_flush, dc_req_vld;
  logic [63:0]   ic_req_addr, dc_req_addr, dc_req_data, cmpl_data;
  logic [1:0]    dc_req_cmd;
  logic [TW-1:0] resp, cmpl_tag;

  logic          ic_ack, dc_ack, ic_rsp_vld, dc_rsp_vld;
  logic [TW-1:0] ic_tag, dc_tag, ic_rsp_tag, dc_rsp_tag, cnt;
  logic [63:0]   ic_rsp_data, dc_rsp_data, bus_addr, bus_data;
  logic [1:0]    bus_cmd;

  logic          s_ic_ack, s_dc_ack, s_ic_rsp_vld, s_dc_rsp_vld;
  logic [TW-1:0] s_ic_tag, s_dc_tag, s_ic_rsp_tag, s_dc_rsp_tag, s_cnt;
  logic [63:0]   s_ic_rsp_data, s_dc_rsp_data, s_bus_addr, s_bus_data;
  logic [1:0]    s_bus_cmd;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.TAG_W(TW), .MAX_OUTSTD(15)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req_vld_i(ic_req_vld), .ic_req_addr_i(ic_req_addr),
    .ic_req_ack_o(ic_ack), .ic_req_tag_o(ic_tag), .ic_flush_i(ic_flush),
    .dc_req_vld_i(dc_req_vld), .dc_req_cmd_i(dc_req_cmd),
    .dc_req_addr_i(dc_req_addr), .dc_req_data_i(dc_req_data),
    .dc_req_ack_o(dc_ack), .dc_req_tag_o(dc_tag),
    .ic_rsp_vld_o(ic_rsp_vld), .ic_rsp_tag_o(ic_rsp_tag), .ic_rsp_data_o(ic_rsp_data),
    .dc_rsp_vld_o(dc_rsp_vld), .dc_rsp_tag_o(dc_rsp_tag), .dc_rsp_data_o(dc_rsp_data),
    .proc2mem_command_o(bus_cmd), .proc2mem_addr_o(bus_addr), .proc2mem_data_o(bus_data),
    .mem2proc_response_i(resp), .mem2proc_data_i(cmpl_data), .mem2proc_tag_i(cmpl_tag),
    .arb_outstd_cnt_o(cnt)
  );

  mem_arbiter #(.TAG_W(TW), .MAX_OUTSTD(2)) u_sat (
    .clk(clk), .rst(rst),
    .ic_req_vld_i(ic_req_vld), .ic_req_addr_i(ic_req_addr),
    .ic_req_ack_o(s_ic_ack), .ic_req_tag_o(s_ic_tag), .ic_flush_i(ic_flush),
    .dc_req_vld_i(dc_req_vld), .dc_req_cmd_i(dc_req_cmd),
    .dc_req_addr_i(dc_req_addr), .dc_req_data_i(dc_req_data),
    .dc_req_ack_o(s_dc_ack), .dc_req_tag_o(s_dc_tag),
    .ic_rsp_vld_o(s_ic_rsp_vld), .ic_rsp_tag_o(s_ic_rsp_tag), .ic_rsp_data_o(s_ic_rsp_data),
    .dc_rsp_vld_o(s_dc_rsp_vld), .dc_rsp_tag_o(s_dc_rsp_tag), .dc_rsp_data_o(s_dc_rsp_data),
    .proc2mem_command_o(s_bus_cmd), .proc2mem_addr_o(s_bus_addr), .proc2mem_data_o(s_bus_data),
    .mem2proc_response_i(resp), .mem2proc_data_i(cmpl_data), .mem2proc_tag_i(cmpl_tag),
    .arb_outstd_cnt_o(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ic_req_vld = 1'b0; ic_req_addr = '0; ic_flush = 1'b0;
    dc_req_vld = 1'b0; dc_req_cmd = BUS_NONE; dc_req_addr = '0; dc_req_data = '0;
    resp = '0; cmpl_tag = '0; cmpl_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic dc_load(input logic [63:0] addr, input logic [TW-1:0] r);
    dc_req_vld = 1'b1; dc_req_cmd = BUS_LOAD; dc_req_addr = addr; resp = r;
  endtask

  initial begin
    // Reset state, with a pending request that must not reach the bus
    idle();
    rst = 1'b1;
    dc_load(64'h100, 4'd3);
    #2;
    chk("rst_cmd", bus_cmd, BUS_NONE);
    chk("rst_dc_ack", dc_ack, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dc_rsp_vld", dc_rsp_vld, 0);
    chk("rst_ic_rsp_vld", ic_rsp_vld, 0);
    do_reset();

    // Load accept and return
    dc_load(64'h100, 4'd3);
    #1;
    chk("ld_ack", dc_ack, 1);
    chk("ld_tag", dc_tag, 3);
    chk("ld_cmd", bus_cmd, BUS_LOAD);
    chk("ld_addr", bus_addr, 64'h100);
    chk("ld_ic_ack", ic_ack, 0);
    cyc();
    idle();
    chk("ld_cnt1", cnt, 1);
    chk("ld_no_rsp", dc_rsp_vld, 0);
    cmpl_tag = 4'd3; cmpl_data = 64'hDEAD; exp_q.push_back(64'hDEAD);
    cyc();
    idle();
    chk("ld_rsp_vld", dc_rsp_vld, 1);
    chk("ld_rsp_tag", dc_rsp_tag, 3);
    chk("ld_rsp_data", dc_rsp_data, exp_q.pop_front());
    chk("ld_cnt0", cnt, 0);
    cyc();
    chk("ld_rsp_pulse", dc_rsp_vld, 0);

    // Simultaneous requests
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic exp_dc;
`ifdef MEM_ARB_RR_EN
      exp_dc = (i % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      ic_req_vld = 1'b1; ic_req_addr = 64'h200;
      dc_load(64'h300, TW'(i + 1));
      #1;
      chk("both_dc_ack", dc_ack, exp_dc);
      chk("both_ic_ack", ic_ack, !exp_dc);
      chk("both_addr", bus_addr, exp_dc ? 64'h300 : 64'h200);
      cyc();
    end
    idle();
    chk("both_cnt", cnt, 4);

    // Flush
    do_reset();
    ic_req_vld = 1'b1; ic_req_addr = 64'h400; resp = 4'd1;
    #1;
    chk("fl_ack1", ic_ack, 1);
    chk("fl_tag1", ic_tag, 1);
    cyc();
    ic_req_addr = 64'h408; resp = 4'd2;
    #1;
    chk("fl_ack2", ic_ack, 1);
    cyc();
    chk("fl_cnt2", cnt, 2);
    ic_flush = 1'b1; ic_req_addr = 64'h480; resp = 4'd4;
    cmpl_tag = 4'd1; cmpl_data = 64'h1111;
    #1;
    chk("fl_ack4", ic_ack, 1);
    chk("fl_tag4", ic_tag, 4);
    cyc();
    idle();
    cmpl_tag = 4'd2; cmpl_data = 64'h2222;
    chk("fl_sup_edge", ic_rsp_vld, 0);
    chk("fl_cnt_edge", cnt, 2);
    cyc();
    cmpl_tag = 4'd4; cmpl_data = 64'hBEEF; exp_q.push_back(64'hBEEF);
    chk("fl_drop2", ic_rsp_vld, 0);
    chk("fl_cnt1", cnt, 1);
    cyc();
    idle();
    chk("fl_new_vld", ic_rsp_vld, 1);
    chk("fl_new_tag", ic_rsp_tag, 4);
    chk("fl_new_data", ic_rsp_data, exp_q.pop_front());
    chk("fl_cnt0", cnt, 0);

    // Saturation on the MAX_OUTSTD=2 instance
    do_reset();
    dc_load(64'h500, 4'd1);
    #1;
    chk("sat_ack1", s_dc_ack, 1);
    cyc();
    dc_load(64'h508, 4'd2);
    #1;
    chk("sat_ack2", s_dc_ack, 1);
    cyc();
    chk("sat_cnt2", s_cnt, 2);
    dc_load(64'h510, 4'd3);
    #1;
    chk("sat_hold_cmd", s_bus_cmd, BUS_NONE);
    chk("sat_hold_ack", s_dc_ack, 0);
    dc_req_cmd = BUS_STORE; dc_req_addr = 64'h600; dc_req_data = 64'h55; resp = 4'd5;
    #1;
    chk("sat_st_cmd", s_bus_cmd, BUS_STORE);
    chk("sat_st_ack", s_dc_ack, 1);
    chk("sat_st_addr", s_bus_addr, 64'h600);
    chk("sat_st_data", s_bus_data, 64'h55);
    cyc();
    chk("sat_st_cnt", s_cnt, 2);
    dc_req_data = '0;
    dc_load(64'h510, 4'd3);
    cmpl_tag = 4'd1; cmpl_data = 64'h11;
    #1;
    chk("sat_still_full", s_bus_cmd, BUS_NONE);
    cyc();
    cmpl_tag = '0;
    dc_load(64'h510, 4'd4);
    chk("sat_rsp", s_dc_rsp_vld, 1);
    #1;
    chk("sat_reissue_cmd", s_bus_cmd, BUS_LOAD);
    chk("sat_reissue_ack", s_dc_ack, 1);
    cyc();
    idle();
    chk("sat_cnt_after", s_cnt, 2);

    // Rejection and same-cycle completion/re-acceptance of one tag
    do_reset();
    dc_load(64'h700, 4'd0);
    #1;
    chk("rej_ack", dc_ack, 0);
    chk("rej_cmd", bus_cmd, BUS_LOAD);
    cyc();
    chk("rej_cnt", cnt, 0);
    dc_load(64'h700, 4'd5);
    #1;
    chk("t5_ack", dc_ack, 1);
    cyc();
    chk("t5_cnt1", cnt, 1);
    dc_load(64'h708, 4'd5);
    cmpl_tag = 4'd5; cmpl_data = 64'hA5A5; exp_q.push_back(64'hA5A5);
    #1;
    chk("t5_reack", dc_ack, 1);
    cyc();
    idle();
    chk("t5_old_vld", dc_rsp_vld, 1);
    chk("t5_old_data", dc_rsp_data, exp_q.pop_front());
    chk("t5_cnt_same", cnt, 1);
    cmpl_tag = 4'd5; cmpl_data = 64'h5A5A; exp_q.push_back(64'h5A5A);
    cyc();
    idle();
    chk("t5_new_vld", dc_rsp_vld, 1);
    chk("t5_new_data", dc_rsp_data, exp_q.pop_front());
    chk("t5_cnt0", cnt, 0);

    // Asynchronous reset with loads in flight
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      dc_load(64'h800 + 64'(i * 8), TW'(i));
      cyc();
    end
    idle();
    cmpl_tag = 4'd1; cmpl_data = 64'h77; exp_q.push_back(64'h77);
    cyc();
    idle();
    chk("ar_pre_vld", dc_rsp_vld, 1);
    chk("ar_pre_data", dc_rsp_data, exp_q.pop_front());
    chk("ar_pre_cnt", cnt, 2);
    #2;
    rst = 1'b1;
    dc_load(64'h900, 4'd6);
    #1;
    chk("ar_vld0", dc_rsp_vld, 0);
    chk("ar_tag0", dc_rsp_tag, 0);
    chk("ar_data0", dc_rsp_data, 0);
    chk("ar_cnt0", cnt, 0);
    chk("ar_cmd", bus_cmd, BUS_NONE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    cmpl_tag = 4'd2; cmpl_data = 64'h22;
    cyc();
    cmpl_tag = 4'd3; cmpl_data = 64'h33;
    chk("ar_stale2", dc_rsp_vld, 0);
    cyc();
    idle();
    chk("ar_stale3", dc_rsp_vld, 0);
    chk("ar_cnt_end", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
